// File: rtl/seg7_pkg.sv
// seg7_pkg: hex-to-seven-segment table and encode helper
package seg7_pkg;
  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
    return SEG7_TABLE[nibble];
  endfunction
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: active-high g..a pattern for one hex nibble
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = seg7_encode(nibble);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered multiplexed seven-segment scanner with anode dead time
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            segment,
  output logic                  frame_tick,
  output logic                  pending
);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam int CW = $clog2(CLK_DIV);
  localparam logic POL = ACTIVE_LOW != 0;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [4*N_DIGITS-1:0] act_data, sh_data;
  logic [N_DIGITS-1:0] act_dp, sh_dp, act_blank, sh_blank;
  logic wrap, fb, lit;
  logic [6:0] seg_pat;
  logic [N_DIGITS-1:0] an_nxt;
  logic [7:0] seg_nxt;
  assign fb = cnt == CW'(CLK_DIV - 1) && idx == IW'(N_DIGITS - 1);
  assign lit = cnt >= CW'(BLANK_CYCLES) && !act_blank[idx];
  assign an_nxt = lit ? N_DIGITS'(1) << idx : '0;
  assign seg_nxt = lit ? {act_dp[idx], seg_pat} : 8'h00;
  seg7_hex_decode u_dec (
    .nibble(act_data[4*idx +: 4]),
    .seg   (seg_pat)
  );
  // slot prescaler and digit index
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(CLK_DIV - 1)) begin
      cnt <= '0;
      idx <= idx == IW'(N_DIGITS - 1) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
  // double buffer: shadow collects loads, active swaps only at the frame boundary
  always_ff @(posedge clk) begin
    if (clr) begin
      act_data  <= '0;
      act_dp    <= '0;
      act_blank <= '1;
      sh_data   <= '0;
      sh_dp     <= '0;
      sh_blank  <= '1;
      pending   <= 1'b0;
    end else if (fb) begin
      act_data  <= load ? data : pending ? sh_data : act_data;
      act_dp    <= load ? dp : pending ? sh_dp : act_dp;
      act_blank <= load ? blank : pending ? sh_blank : act_blank;
      pending   <= 1'b0;
    end else if (load) begin
      sh_data  <= data;
      sh_dp    <= dp;
      sh_blank <= blank;
      pending  <= 1'b1;
    end
  end
  // registered pins; frame_tick lines up with the first output cycle of digit 0
  always_ff @(posedge clk) begin
    if (clr) begin
      an         <= {N_DIGITS{POL}};
      segment    <= {8{POL}};
      wrap       <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_nxt ^ {N_DIGITS{POL}};
      segment    <= seg_nxt ^ {8{POL}};
      wrap       <= fb;
      frame_tick <= wrap;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of scan timing, double buffering, blanking and reset
module tb_seg7_scan_driver;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0] dp = '0;
  logic [3:0] blank = '0;
  logic [3:0] an;
  logic [7:0] segment;
  logic frame_tick, pending;
  int total = 0;
  int bad = 0;
  int n = 0;
  logic [6:0] hex [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  seg7_scan_driver #(
    .N_DIGITS(4),
    .CLK_DIV(8),
    .BLANK_CYCLES(2),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .clr(clr),
    .load(load),
    .data(data),
    .dp(dp),
    .blank(blank),
    .an(an),
    .segment(segment),
    .frame_tick(frame_tick),
    .pending(pending)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask
  task automatic wait_until(input int t);
    while (n < t) step();
  endtask
  task automatic check_frame(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    for (int k = 0; k < 32; k++) begin
      int st, c, i;
      logic en;
      logic [3:0] ean;
      logic [7:0] eseg;
      step();
      st = n - 1;
      c = st % 8;
      i = (st / 8) % 4;
      en = c >= 2 && !b[i];
      ean = en ? ~(4'b1 << i) : 4'hF;
      eseg = en ? ~{p[i], hex[d[4*i +: 4]]} : 8'hFF;
      chk("an", 32'(an), 32'(ean));
      chk("segment", 32'(segment), 32'(eseg));
      chk("frame_tick", 32'(frame_tick), 32'(n % 32 == 1));
      chk("pending_frame", 32'(pending), 0);
    end
  endtask
  initial begin
    step();
    step();
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_segment", 32'(segment), 32'hFF);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_tick", 32'(frame_tick), 0);
    clr = 1'b0;
    n = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      chk("idle_an", 32'(an), 32'hF);
      chk("idle_segment", 32'(segment), 32'hFF);
      chk("idle_pending", 32'(pending), 0);
      chk("idle_tick", 32'(frame_tick), 32'(n == 33));
    end
    load = 1'b1;
    data = 16'h3210;
    step();
    load = 1'b0;
    chk("t2_pending", 32'(pending), 1);
    wait_until(95);
    chk("t2_pending_hold", 32'(pending), 1);
    step();
    chk("t2_pending_clear", 32'(pending), 0);
    check_frame(16'h3210, 4'b0000, 4'b0000);
    load = 1'b1;
    data = 16'h1111;
    step();
    load = 1'b0;
    step();
    step();
    load = 1'b1;
    data = 16'hABCD;
    step();
    load = 1'b0;
    data = 16'h0000;
    chk("t3_pending", 32'(pending), 1);
    wait_until(160);
    chk("t3_pending_clear", 32'(pending), 0);
    check_frame(16'hABCD, 4'b0000, 4'b0000);
    wait_until(223);
    load = 1'b1;
    data = 16'hFFFF;
    dp = 4'b0001;
    step();
    load = 1'b0;
    dp = 4'b0000;
    chk("t4_pending", 32'(pending), 0);
    check_frame(16'hFFFF, 4'b0001, 4'b0000);
    load = 1'b1;
    data = 16'h3210;
    blank = 4'b0100;
    step();
    load = 1'b0;
    blank = 4'b0000;
    chk("t5_pending", 32'(pending), 1);
    wait_until(288);
    check_frame(16'h3210, 4'b0000, 4'b0100);
    wait_until(325);
    load = 1'b1;
    data = 16'h5555;
    step();
    load = 1'b0;
    chk("t6_pending", 32'(pending), 1);
    wait_until(341);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t6_an", 32'(an), 32'hF);
    chk("t6_segment", 32'(segment), 32'hFF);
    chk("t6_pending_clr", 32'(pending), 0);
    chk("t6_tick", 32'(frame_tick), 0);
    n = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      chk("t6_tick_quiet", 32'(frame_tick), 0);
      chk("t6_dark", 32'(an), 32'hF);
    end
    step();
    chk("t6_first_tick", 32'(frame_tick), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
